// File: rtl/instr_encoder.sv
// Instruction field encoder: packs field bundles into 32-bit words through a 2-entry FIFO
// and tags each emitted word with a byte address. Optional group checking under INSTR_ENCODER_ERR_CHECK_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_group,
    input  logic [3:0]  in_ra_index,
    input  logic [3:0]  in_rb_index,
    input  logic [3:0]  in_rc_index,
    input  logic [3:0]  in_opcode,
    input  logic [15:0] in_imm_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    input  logic        load_base,
    input  logic [31:0] base_addr
`ifdef INSTR_ENCODER_ERR_CHECK_EN
    ,
    output logic        err_pulse,
    output logic        err_sticky,
    input  logic        clr_err
`endif
);

    // Group 1 carries an immediate; every other group uses the three-register layout.
    function automatic logic [31:0] encode_word(
        input logic [3:0]  grp,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [3:0]  rc,
        input logic [3:0]  op,
        input logic [15:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (grp)
            4'd1:                w = {grp, ra, rb, op, imm};
            4'd0, 4'd2, 4'd3:    w = {grp, ra, rb, rc, 12'h000, op};
            default:             w = {4'h0, ra, rb, rc, 12'h000, op};
        endcase
        return w;
    endfunction

    logic [1:0]  count_r, count_nxt_s;
    logic [31:0] head_r, head_nxt_s;
    logic [31:0] tail_r, tail_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic        in_ready_r, out_valid_r;
    logic [31:0] word_s;
    logic        accept_s, push_s, pop_s;

    assign word_s   = encode_word(in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode, in_imm_val);
    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

`ifdef INSTR_ENCODER_ERR_CHECK_EN
    logic illegal_s;
    logic err_pulse_r, err_sticky_r;
    assign illegal_s  = accept_s & (in_group > 4'd3);
    assign push_s     = accept_s & ~illegal_s;
    assign err_pulse  = err_pulse_r;
    assign err_sticky = err_sticky_r;

    // Error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            err_pulse_r  <= illegal_s;
            err_sticky_r <= illegal_s ? 1'b1 : (clr_err ? 1'b0 : err_sticky_r);
        end
    end
`else
    assign push_s = accept_s;
`endif

    // FIFO and address next-state; head_r is the output word register.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        addr_nxt_s  = addr_r;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_nxt_s  = word_s;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_nxt_s  = word_s;
                end else if (push_s) begin
                    tail_nxt_s  = word_s;
                    count_nxt_s = 2'd2;
                end else if (pop_s) begin
                    count_nxt_s = 2'd0;
                end else begin
                    count_nxt_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_nxt_s  = tail_r;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd2;
                end
            end
            default: count_nxt_s = 2'd0;
        endcase
        if (load_base) begin
            addr_nxt_s = base_addr & 32'hFFFF_FFFC;
        end else if (pop_s) begin
            addr_nxt_s = addr_r + 32'd4;
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // State registers; ready/valid are precomputed from the next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            head_r      <= 32'h0000_0000;
            tail_r      <= 32'h0000_0000;
            addr_r      <= 32'h0000_0000;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            addr_r      <= addr_nxt_s;
            in_ready_r  <= (count_nxt_s != 2'd2);
            out_valid_r <= (count_nxt_s != 2'd0);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_instr = head_r;
    assign out_addr  = addr_r;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: in_valid  input  1  field bundle present.
REQ-004 SHALL: in_ready  output  1  encoder can accept bundle.
REQ-005 SHALL: in_group  input  4  instruction group, 0..3 legal.
REQ-006 SHALL: in_ra_index, in_rb_index, in_rc_index  input  4 each  register indices.
REQ-007 SHALL: in_opcode  input  4  opcode within group.
REQ-008 SHALL: in_imm_val  input  16  immediate, used by group 1 only.
REQ-009 SHALL: out_valid  output  1  encoded word available.
REQ-010 SHALL: out_ready  input  1  consumer takes word.
REQ-011 SHALL: out_instr  output  32  encoded instruction word.
REQ-012 SHALL: out_addr  output  32  byte address assigned to out_instr.
REQ-013 SHALL: load_base  input  1  pulse, load base_addr into address counter.
REQ-014 SHALL: base_addr  input  32  new counter value, 4-byte aligned.

Function
REQ-015 SHALL: encoding, all groups: [31:28]=group, [27:24]=ra, [23:20]=rb.
REQ-016 SHALL: groups 0,2,3: [19:16]=rc, [15:4]=0, [3:0]=opcode; in_imm_val ignored.
REQ-017 SHALL: group 1: [19:16]=opcode, [15:0]=imm_val; in_rc_index ignored.
REQ-018 SHALL: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-019 SHALL: 2-entry FIFO holds encoded words; in_ready = (count < 2), independent of out_ready.
REQ-020 SHALL: latency: bundle accepted at edge N -> word on out_instr with out_valid=1 after edge N (1 cycle); no combinational in->out path.
REQ-021 SHALL: out_instr/out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL: simultaneous push and pop with count=1 leaves count=1, order preserved.
REQ-023 SHALL: empty FIFO: out_valid=0, out_instr holds last value (don't-care to consumer).
REQ-024 SHALL: address counter increments by 4 per output handshake, wraps 0xFFFFFFFC -> 0x00000000.
REQ-025 SHALL: out_addr = counter value; load_base in same cycle as output handshake: load wins, no increment.
REQ-026 SHALL: load_base does not disturb FIFO contents; next emitted word gets base_addr.
REQ-027 SHALL: base_addr[1:0] ignored, counter bits [1:0] always 0.

Reset
REQ-028 SHALL: rst_n=0 at edge: FIFO count=0, out_valid=0, out_instr=0, out_addr=0, in_ready=1 after that edge.
REQ-029 SHALL: reset mid-transfer discards all queued words; no partial word emitted.
REQ-030 SHALL: reset overrides load_base and all handshakes in same cycle.

Configuration
REQ-031 SHALL: macro INSTR_ENCODER_ERR_CHECK_EN defined: adds outputs err_pulse(1), err_sticky(1), input clr_err(1).
REQ-032 SHALL: with macro: accepted bundle with in_group>3 not enqueued, err_pulse=1 one cycle, err_sticky=1 until clr_err or reset; clr_err and new error same cycle: sticky stays 1.
REQ-033 SHALL: with macro: err_pulse=0, err_sticky=0 on reset.
REQ-034 SHALL: without macro: in_group>3 encoded with group field 0 and group-0 layout; no error ports exist.

Verification
REQ-035 SHALL: group 0, ra=1 rb=2 rc=3 op=5, out_ready=1 -> out_instr=0x01230005 one cycle later, out_addr=0.
REQ-036 SHALL: group 1, ra=4 rb=5 op=0xA imm=0xBEEF -> out_instr=0x145ABEEF.
REQ-037 SHALL: out_ready=0, push 3 bundles -> in_ready=0 after 2, third held; release -> words in order, addrs 0,4,8.
REQ-038 SHALL: load_base base_addr=0xFFFFFFFC, emit 2 words -> out_addr 0xFFFFFFFC then 0x00000000.
REQ-039 SHALL: with macro, group=7 -> no word, err_pulse 1 cycle, err_sticky=1 until clr_err; without macro -> out_instr[31:28]=0.
REQ-040 SHALL: rst_n=0 with 2 words queued -> next cycle out_valid=0, in_ready=1, out_addr=0.
